// File: rtl/dot_accum_pkg.sv
// dot_accum_pkg: shared state encoding and default widths for the dot_accum slice
package dot_accum_pkg;
  typedef enum logic [1:0] {IDLE, ACC, DONE} dot_accum_state_t;
  localparam int DOT_DW    = 32;
  localparam int DOT_AW    = 40;
  localparam int DOT_LEN_W = 8;
endpackage

// File: rtl/dot_accum_if.sv
// dot_accum_if: partial-sum input, frame control and result handshake bundle
interface dot_accum_if
  import dot_accum_pkg::*;
#(
  parameter int DW    = DOT_DW,
  parameter int AW    = DOT_AW,
  parameter int LEN_W = DOT_LEN_W
);
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic [LEN_W-1:0] len;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [AW-1:0]    out_data;
  logic             out_ovf;
  modport master (
    output in_valid, in_data, len, flush, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );
  modport slave (
    input  in_valid, in_data, len, flush, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/dot_accum_sat_add.sv
// sat_add: AW-bit adder with carry flag; saturates to all-ones when DOT_ACCUM_SAT_EN is defined
module sat_add #(
  parameter int AW = 40
) (
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] b,
  output logic [AW-1:0] sum,
  output logic          carry
);
  logic [AW:0] raw;
  assign raw   = {1'b0, a} + {1'b0, b};
  assign carry = raw[AW];
`ifdef DOT_ACCUM_SAT_EN
  assign sum = carry ? '1 : raw[AW-1:0];
`else
  assign sum = raw[AW-1:0];
`endif
endmodule

// File: rtl/dot_accum.sv
// dot_accum: accumulates len partial sums into one dot product (DOT_ACCUM_SAT_EN selects saturation)
module dot_accum
  import dot_accum_pkg::*;
#(
  parameter int DW    = DOT_DW,
  parameter int AW    = DOT_AW,
  parameter int LEN_W = DOT_LEN_W
) (
  input  logic     clk,
  input  logic     rst_n,
  dot_accum_if.slave bus
);
  dot_accum_state_t state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d, sum;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d, len_eff;
  logic             ovf_q, ovf_d, out_valid_q, out_valid_d;
  logic [DW-1:0]    in_data;
  logic             in_ready, idle, beat, carry;
  assign in_data  = bus.in_data;
  assign in_ready = state_q != DONE;
  assign idle     = state_q == IDLE;
  assign beat     = bus.in_valid && in_ready;
  assign len_eff  = bus.len == '0 ? LEN_W'(1) : bus.len;
  // The first beat of a frame adds onto zero, so one adder serves both states
  sat_add #(.AW(AW)) u_add (
    .a     (idle ? '0 : acc_q),
    .b     (AW'(in_data)),
    .sum   (sum),
    .carry (carry)
  );
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    if (bus.flush) begin
      state_d     = IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else if (state_q == DONE) begin
      state_d     = bus.out_ready ? IDLE : DONE;
      out_valid_d = !bus.out_ready;
    end else if (beat) begin
      acc_d       = sum;
      len_d       = idle ? len_eff : len_q;
      cnt_d       = idle ? LEN_W'(1) : cnt_q + 1'b1;
      ovf_d       = carry || (!idle && ovf_q);
      state_d     = cnt_d == len_d ? DONE : ACC;
      out_valid_d = cnt_d == len_d;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = acc_q;
  assign bus.out_ovf   = ovf_q;
endmodule
